// File: rtl/lcd_nibble_timing.sv
// HD44780 4-bit bus driver: presents one nibble per accepted start with setup/E-width/hold
// timing, waits out the controller execution time, then pulses done for one cycle.
module lcd_nibble_timing #(
    parameter int SETUP_CYCLES  = 2,
    parameter int E_HIGH_CYCLES = 12,
    parameter int HOLD_CYCLES   = 2,
    parameter int WAIT_EXEC     = 1000,
    parameter int WAIT_LONG     = 41000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] nibble_in,
    input  logic       rs_in,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [3:0] lcd_data,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_E_HIGH = 3'd2,
        S_HOLD   = 3'd3,
        S_EXEC   = 3'd4
    } state_t;

    // Counter reload values: each phase counts down to zero, so load length-1.
    localparam logic [16:0] C_SETUP = 17'(SETUP_CYCLES - 1);
    localparam logic [16:0] C_E_HI  = 17'(E_HIGH_CYCLES - 1);
    localparam logic [16:0] C_HOLD  = 17'(HOLD_CYCLES - 1);
    localparam logic [16:0] C_EXEC  = 17'(WAIT_EXEC - 1);
    localparam logic [16:0] C_LONG  = 17'(WAIT_LONG - 1);

    state_t      r_state;
    logic [16:0] r_cnt;
    logic        r_e;
    logic        r_rs;
    logic [3:0]  r_data;
    logic        r_busy;
    logic        r_done;
    logic        r_long;
    logic        r_prev_cmd_zero;

    state_t      w_state_nxt;
    logic [16:0] w_cnt_nxt;
    logic        w_e_nxt;
    logic        w_rs_nxt;
    logic [3:0]  w_data_nxt;
    logic        w_busy_nxt;
    logic        w_done_nxt;
    logic        w_long_nxt;
    logic        w_prev_nxt;
    logic        w_cnt_zero;
    logic        w_long_sel;

    assign w_cnt_zero = (r_cnt == 17'd0);

    // Low nibble of clear (0x01) or return-home (0x02/0x03) following a 0x0 command nibble.
    // Byte phase is not tracked, so a false long wait is possible and harmless.
    assign w_long_sel = !rs_in && r_prev_cmd_zero &&
                        ((nibble_in == 4'd1) || (nibble_in == 4'd2) || (nibble_in == 4'd3));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_cnt           <= 17'd0;
            r_e             <= 1'b0;
            r_rs            <= 1'b0;
            r_data          <= 4'd0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_long          <= 1'b0;
            r_prev_cmd_zero <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_cnt           <= w_cnt_nxt;
            r_e             <= w_e_nxt;
            r_rs            <= w_rs_nxt;
            r_data          <= w_data_nxt;
            r_busy          <= w_busy_nxt;
            r_done          <= w_done_nxt;
            r_long          <= w_long_nxt;
            r_prev_cmd_zero <= w_prev_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_e_nxt     = r_e;
        w_rs_nxt    = r_rs;
        w_data_nxt  = r_data;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_long_nxt  = r_long;
        w_prev_nxt  = r_prev_cmd_zero;

        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_data_nxt  = nibble_in;
                    w_rs_nxt    = rs_in;
                    w_busy_nxt  = 1'b1;
                    w_long_nxt  = w_long_sel;
                    w_prev_nxt  = !rs_in && (nibble_in == 4'd0);
                    w_cnt_nxt   = C_SETUP;
                    w_state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                if (w_cnt_zero) begin
                    w_e_nxt     = 1'b1;
                    w_cnt_nxt   = C_E_HI;
                    w_state_nxt = S_E_HIGH;
                end else begin
                    w_cnt_nxt = r_cnt - 17'd1;
                end
            end
            S_E_HIGH: begin
                if (w_cnt_zero) begin
                    w_e_nxt     = 1'b0;
                    w_cnt_nxt   = C_HOLD;
                    w_state_nxt = S_HOLD;
                end else begin
                    w_cnt_nxt = r_cnt - 17'd1;
                end
            end
            S_HOLD: begin
                if (w_cnt_zero) begin
                    w_cnt_nxt   = r_long ? C_LONG : C_EXEC;
                    w_state_nxt = S_EXEC;
                end else begin
                    w_cnt_nxt = r_cnt - 17'd1;
                end
            end
            S_EXEC: begin
                if (w_cnt_zero) begin
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 17'd1;
                end
            end
            default: begin
                w_e_nxt     = 1'b0;
                w_busy_nxt  = 1'b0;
                w_cnt_nxt   = 17'd0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign lcd_e    = r_e;
    assign lcd_rs   = r_rs;
    assign lcd_rw   = 1'b0;
    assign lcd_data = r_data;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_lcd_nibble_timing.sv
// Bench for lcd_nibble_timing: directed scenarios plus randomized traffic, every cycle
// compared against a transaction-interval model of the nibble timing.
module tb_lcd_nibble_timing;

    localparam int S  = 2;
    localparam int EH = 4;
    localparam int H  = 2;
    localparam int WE = 10;
    localparam int WL = 50;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] nibble_in = 4'd0;
    logic       rs_in = 1'b0;
    logic       lcd_e, lcd_rs, lcd_rw, busy, done;
    logic [3:0] lcd_data;

    always #5 clk = ~clk;

    lcd_nibble_timing #(
        .SETUP_CYCLES(S), .E_HIGH_CYCLES(EH), .HOLD_CYCLES(H),
        .WAIT_EXEC(WE), .WAIT_LONG(WL)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .nibble_in(nibble_in), .rs_in(rs_in),
        .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_data(lcd_data),
        .busy(busy), .done(done)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: a transaction is an accept edge plus a total length; outputs are
    // simple interval tests on the edge count.
    int         cyc = 0;
    bit         chk_en = 0;
    bit         m_active = 0;
    int         m_acc = 0;
    int         m_len = 0;
    bit         m_prev = 0;
    logic [3:0] m_data = 4'd0;
    logic       m_rs = 1'b0;
    logic [3:0] last_data = 4'd0;

    function automatic int lat_for(input logic [3:0] n, input logic r);
        return S + EH + H + ((!r && m_prev && n >= 4'd1 && n <= 4'd3) ? WL : WE);
    endfunction

    always @(posedge clk) begin
        cyc++;
        chk_en = 1;
        if (rst) begin
            m_active = 0;
            m_prev   = 0;
            m_data   = 4'd0;
            m_rs     = 1'b0;
        end else if (start && !(m_active && cyc <= m_acc + m_len)) begin
            m_len    = lat_for(nibble_in, rs_in);
            m_acc    = cyc;
            m_active = 1;
            m_prev   = !rs_in && (nibble_in == 4'd0);
            m_data   = nibble_in;
            m_rs     = rs_in;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check_eq("busy", busy, m_active && cyc < m_acc + m_len);
            check_eq("done", done, m_active && cyc == m_acc + m_len);
            check_eq("lcd_e", lcd_e, m_active && cyc >= m_acc + S && cyc < m_acc + S + EH);
            check_eq("lcd_data", lcd_data, m_data);
            check_eq("lcd_rs", lcd_rs, m_rs);
            check_eq("lcd_rw", lcd_rw, 1'b0);
            if (lcd_e) check_eq("e_data_stable", lcd_data, last_data);
            last_data = lcd_data;
        end
    end

    // Called at the negedge after the accept edge; returns cycles from accept to done.
    task automatic wait_done(input bit noise, output int lat);
        lat = 0;
        while (!done && lat < 200) begin
            if (noise) begin
                start     = 1'($urandom_range(0, 1));
                nibble_in = 4'($urandom_range(0, 15));
                rs_in     = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        if (!done) check_eq("done_timeout", lat, 32'd0);
    endtask

    task automatic issue(input logic [3:0] n, input logic r, input bit noise, output int lat);
        exp_q.push_back(32'(lat_for(n, r)));
        start     = 1'b1;
        nibble_in = n;
        rs_in     = r;
        @(posedge clk);
        @(negedge clk);
        start     = 1'b0;
        nibble_in = 4'($urandom_range(0, 15));
        rs_in     = 1'($urandom_range(0, 1));
        wait_done(noise, lat);
        check_eq($sformatf("latency n=%0h rs=%0d", n, r), lat, exp_q.pop_front());
    endtask

    logic [3:0] init_seq [12] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8,
                                  4'h0, 4'hC, 4'h0, 4'h6, 4'h0, 4'h1};

    initial begin
        int lat;
        int dones;
        logic [3:0] n;
        logic r;

        repeat (3) @(negedge clk);
        check_eq("rst_e", lcd_e, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_data", lcd_data, 4'h0);
        check_eq("rst_rs", lcd_rs, 1'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single data nibble
        issue(4'hA, 1'b1, 1'b0, lat);
        check_eq("single_lat", lat, 32'd18);
        @(negedge clk);
        check_eq("single_done_pulse", done, 1'b0);
        check_eq("single_data_held", lcd_data, 4'hA);
        check_eq("single_rs_held", lcd_rs, 1'b1);

        // Clear and entry-mode command pairs, back-to-back on done
        issue(4'h0, 1'b0, 1'b0, lat);
        check_eq("clr_hi_lat", lat, 32'd18);
        issue(4'h1, 1'b0, 1'b0, lat);
        check_eq("clr_lo_lat", lat, 32'd58);
        issue(4'h0, 1'b0, 1'b0, lat);
        issue(4'h6, 1'b0, 1'b0, lat);
        check_eq("entry_lo_lat", lat, 32'd18);

        // Start while busy is ignored
        @(negedge clk);
        start = 1'b1; nibble_in = 4'h3; rs_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        start = 1'b1; nibble_in = 4'h5; rs_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check_eq("busy_ignore_data", lcd_data, 4'h3);
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dones++;
        end
        check_eq("busy_ignore_dones", dones, 32'd1);
        check_eq("busy_ignore_data_end", lcd_data, 4'h3);

        // Init-sequence replay
        foreach (init_seq[i]) begin
            issue(init_seq[i], 1'b0, 1'b0, lat);
            check_eq($sformatf("init_lat[%0d]", i), lat, (i == 11) ? 32'd58 : 32'd18);
        end

        // Reset during E high
        @(negedge clk);
        start = 1'b1; nibble_in = 4'h9; rs_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("e_before_rst", lcd_e, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("midrst_e", lcd_e, 1'b0);
        check_eq("midrst_busy", busy, 1'b0);
        rst = 1'b0;
        dones = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) dones++;
        end
        check_eq("midrst_no_done", dones, 32'd0);
        issue(4'hA, 1'b1, 1'b0, lat);
        check_eq("post_rst_lat", lat, 32'd18);

        // Data write of 0x1 after a 0x0 command is not a clear
        issue(4'h0, 1'b0, 1'b0, lat);
        issue(4'h1, 1'b1, 1'b0, lat);
        check_eq("data_1_lat", lat, 32'd18);

        // Randomized traffic with idle gaps and ignored starts while busy
        repeat (40) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if ($urandom_range(0, 2) == 0) issue(4'h0, 1'b0, 1'b1, lat);
            n = 4'($urandom_range(0, 15));
            r = ($urandom_range(0, 3) == 0);
            issue(n, r, 1'b1, lat);
        end

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule
